// File: rtl/cpu_dcache_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_dcache_arbiter
//  Purpose  : Shares the single data-cache port between the CPU memory stage
//             (port A) and a secondary debug/DMA master (port B). Round-robin
//             arbitration, port A bus locking for atomic sequences, registered
//             command to the cache, zero-latency ready/rdata return.
//  Revision : 1.0  initial release
// ============================================================================
module cpu_dcache_arbiter (
   input  logic        i_clock,
   input  logic        i_reset,

   // Port A: CPU memory stage
   input  logic        i_a_rw,
   input  logic        i_a_request,
   input  logic        i_a_flush,
   input  logic        i_a_cacheable,
   input  logic        i_a_lock,
   input  logic [31:0] i_a_address,
   input  logic [31:0] i_a_wdata,
   output logic        o_a_ready,
   output logic [31:0] o_a_rdata,

   // Port B: debug / DMA master
   input  logic        i_b_rw,
   input  logic        i_b_request,
   input  logic        i_b_flush,
   input  logic        i_b_cacheable,
   input  logic [31:0] i_b_address,
   input  logic [31:0] i_b_wdata,
   output logic        o_b_ready,
   output logic [31:0] o_b_rdata,

   // Data cache side
   output logic        o_rw,
   output logic        o_request,
   output logic        o_flush,
   output logic        o_cacheable,
   output logic [31:0] o_address,
   output logic [31:0] o_wdata,
   input  logic        i_ready,
   input  logic [31:0] i_rdata,

   // Debug: completed transactions per port
   output logic [31:0] o_grants_a,
   output logic [31:0] o_grants_b
);

   // IDLE     : arbitration happens here, one decision per visit
   // GRANT_A/B: command held on the cache port until the cache answers
   // RELEASE  : one dead cycle so the cache always sees request low after ready
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_A = 2'd1,
      GRANT_B = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   // prio   : which port wins a tie in IDLE (0 = A, 1 = B)
   // locked : port A holds the cache; B may not be granted while set
   logic   prio;
   logic   prio_next;
   logic   locked;
   logic   locked_next;

   // Single-cycle strobes out of the next-state logic
   logic   grant_a;      // IDLE decision: start a port A transaction
   logic   grant_b;      // IDLE decision: start a port B transaction
   logic   complete_a;   // cache answered the port A transaction
   logic   complete_b;   // cache answered the port B transaction

   // Next-state, arbitration and completion decode
   always_comb begin
      state_next  = state;
      prio_next   = prio;
      locked_next = locked;
      grant_a     = 1'b0;
      grant_b     = 1'b0;
      complete_a  = 1'b0;
      complete_b  = 1'b0;

      case (state)
         IDLE: begin
            if (locked) begin
               // Port A owns the cache: B waits no matter what prio says.
               grant_a = i_a_request;
               // A releasing its lock while idle frees the cache for later
               // arbitration; if A is also granted now, its completion will
               // rewrite locked anyway.
               if (!i_a_lock) begin
                  locked_next = 1'b0;
               end
            end else if (i_a_request && i_b_request) begin
               grant_a = ~prio;
               grant_b = prio;
            end else begin
               grant_a = i_a_request;
               grant_b = i_b_request;
            end

            if (grant_a) begin
               state_next = GRANT_A;
            end else if (grant_b) begin
               state_next = GRANT_B;
            end
         end

         GRANT_A: begin
            if (i_ready) begin
               complete_a  = 1'b1;
               prio_next   = 1'b1;
               // Lock is sampled in the ready cycle so A can chain an
               // atomic read-modify-write without B slipping in between.
               locked_next = i_a_lock;
               state_next  = RELEASE;
            end
         end

         GRANT_B: begin
            if (i_ready) begin
               complete_b  = 1'b1;
               prio_next   = 1'b0;
               locked_next = 1'b0;
               state_next  = RELEASE;
            end
         end

         RELEASE: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, priority and lock registers
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state  <= IDLE;
         prio   <= 1'b0;
         locked <= 1'b0;
      end else begin
         state  <= state_next;
         prio   <= prio_next;
         locked <= locked_next;
      end
   end

   // Cache command registers: captured on grant, held until the next grant
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         o_request   <= 1'b0;
         o_rw        <= 1'b0;
         o_flush     <= 1'b0;
         o_cacheable <= 1'b0;
         o_address   <= 32'd0;
         o_wdata     <= 32'd0;
      end else if (grant_a) begin
         o_request   <= 1'b1;
         o_rw        <= i_a_rw;
         o_flush     <= i_a_flush;
         o_cacheable <= i_a_cacheable;
         o_address   <= i_a_address;
         o_wdata     <= i_a_wdata;
      end else if (grant_b) begin
         o_request   <= 1'b1;
         o_rw        <= i_b_rw;
         o_flush     <= i_b_flush;
         o_cacheable <= i_b_cacheable;
         o_address   <= i_b_address;
         o_wdata     <= i_b_wdata;
      end else if (complete_a || complete_b) begin
         // Drop request right after the ready pulse; the other fields stay
         // put so the cache never sees them glitch.
         o_request   <= 1'b0;
      end
   end

   // Completed-transaction counters, wrapping naturally at 2^32
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         o_grants_a <= 32'd0;
         o_grants_b <= 32'd0;
      end else begin
         if (complete_a) begin
            o_grants_a <= o_grants_a + 32'd1;
         end
         if (complete_b) begin
            o_grants_b <= o_grants_b + 32'd1;
         end
      end
   end

   // Ready goes only to the port that owns the cache. Reset in the same
   // cycle suppresses it, because the transaction is being abandoned.
   assign o_a_ready = i_ready & (state == GRANT_A) & ~i_reset;
   assign o_b_ready = i_ready & (state == GRANT_B) & ~i_reset;

   // Read data is shared; each port qualifies it with its own ready.
   assign o_a_rdata = i_rdata;
   assign o_b_rdata = i_rdata;

endmodule
`default_nettype wire

// File: tb/tb_cpu_dcache_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_dcache_arbiter
//  Purpose  : Self-checking bench for cpu_dcache_arbiter: directed scenarios
//             followed by randomized traffic against a transaction-level
//             reference model (owner / earliest-idle-cycle bookkeeping).
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu_dcache_arbiter;

   logic        i_clock = 1'b0;
   logic        i_reset;
   logic        i_a_rw, i_a_request, i_a_flush, i_a_cacheable, i_a_lock;
   logic [31:0] i_a_address, i_a_wdata;
   logic        o_a_ready;
   logic [31:0] o_a_rdata;
   logic        i_b_rw, i_b_request, i_b_flush, i_b_cacheable;
   logic [31:0] i_b_address, i_b_wdata;
   logic        o_b_ready;
   logic [31:0] o_b_rdata;
   logic        o_rw, o_request, o_flush, o_cacheable;
   logic [31:0] o_address, o_wdata;
   logic        i_ready;
   logic [31:0] i_rdata;
   logic [31:0] o_grants_a, o_grants_b;

   int vectors     = 0;
   int miscompares = 0;

   always #5 i_clock = ~i_clock;

   cpu_dcache_arbiter dut (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_a_rw       (i_a_rw),
      .i_a_request  (i_a_request),
      .i_a_flush    (i_a_flush),
      .i_a_cacheable(i_a_cacheable),
      .i_a_lock     (i_a_lock),
      .i_a_address  (i_a_address),
      .i_a_wdata    (i_a_wdata),
      .o_a_ready    (o_a_ready),
      .o_a_rdata    (o_a_rdata),
      .i_b_rw       (i_b_rw),
      .i_b_request  (i_b_request),
      .i_b_flush    (i_b_flush),
      .i_b_cacheable(i_b_cacheable),
      .i_b_address  (i_b_address),
      .i_b_wdata    (i_b_wdata),
      .o_b_ready    (o_b_ready),
      .o_b_rdata    (o_b_rdata),
      .o_rw         (o_rw),
      .o_request    (o_request),
      .o_flush      (o_flush),
      .o_cacheable  (o_cacheable),
      .o_address    (o_address),
      .o_wdata      (o_wdata),
      .i_ready      (i_ready),
      .i_rdata      (i_rdata),
      .o_grants_a   (o_grants_a),
      .o_grants_b   (o_grants_b)
   );

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs change here.
   task automatic tick();
      @(posedge i_clock);
      #1;
   endtask

   task automatic clear_inputs();
      i_a_rw = 0; i_a_request = 0; i_a_flush = 0; i_a_cacheable = 0; i_a_lock = 0;
      i_a_address = 0; i_a_wdata = 0;
      i_b_rw = 0; i_b_request = 0; i_b_flush = 0; i_b_cacheable = 0;
      i_b_address = 0; i_b_wdata = 0;
      i_ready = 0; i_rdata = 0;
   endtask

   // Two reset edges, then return in the first cycle with reset low.
   task automatic do_reset();
      clear_inputs();
      i_reset = 1;
      tick();
      tick();
      i_reset = 0;
   endtask

   // Wait (bounded) until the command shows up on the cache port; returns
   // at the falling edge of the first cycle with o_request high.
   task automatic wait_grant(input string tag);
      int k;
      k = 0;
      @(negedge i_clock);
      while (!o_request && k < 20) begin
         tick();
         @(negedge i_clock);
         k++;
      end
      chk1({tag, "_granted"}, o_request, 1'b1);
   endtask

   // Expect a grant to the given port/address, answer it after lat cycles.
   task automatic serve(input string tag, input logic exp_b, input logic [31:0] exp_addr,
                        input int lat, input logic [31:0] rd);
      wait_grant(tag);
      chk32({tag, "_addr"}, o_address, exp_addr);
      for (int k = 1; k < lat; k++) tick();
      tick();
      i_ready = 1;
      i_rdata = rd;
      @(negedge i_clock);
      chk1({tag, "_a_ready"}, o_a_ready, ~exp_b);
      chk1({tag, "_b_ready"}, o_b_ready, exp_b);
      chk32({tag, "_rdata"}, exp_b ? o_b_rdata : o_a_rdata, rd);
      tick();
      i_ready = 0;
   endtask

   // ---------------- reference model and random agents ----------------
   int          n;
   int          m_owner;     // 0 none, 1 port A, 2 port B
   int          m_idle_at;   // first cycle the arbiter may take a decision
   int          m_pick;
   logic        m_prio, m_locked;
   logic [31:0] m_ga, m_gb;
   logic        m_rw, m_flush, m_cach;
   logic [31:0] m_addr, m_wdata;
   logic        want_a, want_b;

   logic        a_pend, b_pend, a_done, b_done;
   int          a_gap, b_gap;
   logic        c_busy, prev_req;
   int          c_cnt;

   initial begin
      #400000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      // ---------------- reset state ----------------
      clear_inputs();
      i_reset = 1;
      tick();
      tick();
      @(negedge i_clock);
      chk1 ("rst_request",   o_request,   1'b0);
      chk1 ("rst_rw",        o_rw,        1'b0);
      chk1 ("rst_flush",     o_flush,     1'b0);
      chk1 ("rst_cacheable", o_cacheable, 1'b0);
      chk32("rst_address",   o_address,   32'd0);
      chk32("rst_wdata",     o_wdata,     32'd0);
      chk32("rst_grants_a",  o_grants_a,  32'd0);
      chk32("rst_grants_b",  o_grants_b,  32'd0);
      chk1 ("rst_a_ready",   o_a_ready,   1'b0);
      chk1 ("rst_b_ready",   o_b_ready,   1'b0);
      tick();
      i_reset = 0;

      // ---------------- single A read, one-cycle arbitration ----------------
      i_a_request = 1; i_a_rw = 0; i_a_cacheable = 1; i_a_address = 32'h0000_1000;
      @(negedge i_clock);
      chk1("a_read_not_yet", o_request, 1'b0);
      tick();
      @(negedge i_clock);
      chk1 ("a_read_latency", o_request, 1'b1);
      chk1 ("a_read_rw",      o_rw,      1'b0);
      chk1 ("a_read_cach",    o_cacheable, 1'b1);
      serve("a_read", 1'b0, 32'h0000_1000, 2, 32'hDEAD_BEEF);
      i_a_request = 0;
      @(negedge i_clock);
      chk1 ("a_read_release_req", o_request,  1'b0);
      chk32("a_read_grants_a",    o_grants_a, 32'd1);
      chk32("a_read_grants_b",    o_grants_b, 32'd0);

      // ---------------- sustained contention: ABAB... ----------------
      do_reset();
      i_a_request = 1; i_a_address = 32'hA000_0000;
      i_b_request = 1; i_b_address = 32'hB000_0000;
      for (int i = 0; i < 10; i++) begin
         serve($sformatf("alt%0d", i), 1'(i % 2), (i % 2) ? 32'hB000_0000 : 32'hA000_0000,
               1 + (i % 3), 32'h1111_0000 + 32'(i));
      end
      i_a_request = 0; i_b_request = 0;
      @(negedge i_clock);
      chk32("alt_grants_a", o_grants_a, 32'd5);
      chk32("alt_grants_b", o_grants_b, 32'd5);

      // ---------------- locked read-modify-write ----------------
      do_reset();
      i_b_request = 1; i_b_address = 32'hB000_0010;
      i_a_request = 1; i_a_lock = 1; i_a_rw = 0; i_a_address = 32'h0000_2000;
      serve("lock_rd", 1'b0, 32'h0000_2000, 2, 32'h0000_00AA);
      i_a_rw = 1; i_a_wdata = 32'h1234_5678; i_a_lock = 0;
      serve("lock_wr", 1'b0, 32'h0000_2000, 1, 32'h0);
      chk1 ("lock_wr_rw",    o_rw,    1'b1);
      chk32("lock_wr_wdata", o_wdata, 32'h1234_5678);
      i_a_request = 0;
      @(negedge i_clock);
      chk32("lock_grants_a", o_grants_a, 32'd2);
      chk32("lock_grants_b", o_grants_b, 32'd0);
      serve("lock_b", 1'b1, 32'hB000_0010, 1, 32'h0000_00BB);
      i_b_request = 0;

      // ---------------- B flush with A arriving mid-transaction ----------------
      i_b_request = 1; i_b_flush = 1; i_b_address = 32'hB000_0040;
      wait_grant("flush");
      chk1("flush_o_flush", o_flush, 1'b1);
      tick();
      i_a_request = 1; i_a_rw = 0; i_a_address = 32'hA000_0080;
      @(negedge i_clock);
      chk1 ("flush_held",      o_flush,   1'b1);
      chk32("flush_addr_held", o_address, 32'hB000_0040);
      tick();
      i_ready = 1; i_rdata = 32'h0;
      @(negedge i_clock);
      chk1("flush_b_ready", o_b_ready, 1'b1);
      chk1("flush_a_ready", o_a_ready, 1'b0);
      tick();
      i_ready = 0; i_b_request = 0; i_b_flush = 0;
      serve("after_flush", 1'b0, 32'hA000_0080, 1, 32'hCAFE_F00D);
      chk1("after_flush_o_flush", o_flush, 1'b0);
      i_a_request = 0;
      @(negedge i_clock);
      chk32("flush_grants_b", o_grants_b, 32'd2);

      // ---------------- reset during GRANT_B together with ready ----------------
      i_b_request = 1; i_b_address = 32'hB000_0100;
      wait_grant("rst_b");
      tick();
      i_reset = 1; i_ready = 1; i_rdata = 32'h5555_AAAA;
      @(negedge i_clock);
      chk1("rst_b_b_ready", o_b_ready, 1'b0);
      chk1("rst_b_a_ready", o_a_ready, 1'b0);
      tick();
      i_reset = 0; i_ready = 0; i_b_request = 0;
      @(negedge i_clock);
      chk1 ("rst_b_request",  o_request,  1'b0);
      chk32("rst_b_grants_b", o_grants_b, 32'd0);

      // ---------------- stray ready in IDLE ----------------
      tick();
      i_ready = 1; i_rdata = 32'h0BAD_0BAD;
      @(negedge i_clock);
      chk1("stray_a_ready", o_a_ready, 1'b0);
      chk1("stray_b_ready", o_b_ready, 1'b0);
      tick();
      i_ready = 0;
      @(negedge i_clock);
      chk32("stray_grants_a", o_grants_a, 32'd0);
      chk32("stray_grants_b", o_grants_b, 32'd0);
      chk1 ("stray_request",  o_request,  1'b0);

      // ---------------- randomized traffic vs. reference model ----------------
      do_reset();
      n = 0; m_owner = 0; m_idle_at = 0; m_prio = 0; m_locked = 0;
      m_ga = 0; m_gb = 0;
      m_rw = 0; m_flush = 0; m_cach = 0; m_addr = 0; m_wdata = 0;
      a_pend = 0; b_pend = 0; a_done = 0; b_done = 0;
      a_gap = $urandom_range(0, 3); b_gap = $urandom_range(0, 3);
      c_busy = 0; c_cnt = 0; prev_req = 0;

      repeat (1500) begin
         // requester A
         if (a_done) begin a_pend = 0; a_gap = $urandom_range(0, 3); end
         if (!a_pend) begin
            if (a_gap == 0) begin
               a_pend = 1;
               i_a_rw = 1'($urandom); i_a_flush = ($urandom_range(0, 7) == 0);
               i_a_cacheable = 1'($urandom); i_a_address = $urandom; i_a_wdata = $urandom;
               i_a_lock = ($urandom_range(0, 2) == 0);
            end else begin
               a_gap--;
               i_a_lock = 1'($urandom);
            end
         end
         i_a_request = a_pend;
         // requester B
         if (b_done) begin b_pend = 0; b_gap = $urandom_range(0, 3); end
         if (!b_pend) begin
            if (b_gap == 0) begin
               b_pend = 1;
               i_b_rw = 1'($urandom); i_b_flush = ($urandom_range(0, 7) == 0);
               i_b_cacheable = 1'($urandom); i_b_address = $urandom; i_b_wdata = $urandom;
            end else begin
               b_gap--;
            end
         end
         i_b_request = b_pend;
         // cache: answers 1..3 cycles after accepting, plus rare stray pulses
         i_ready = 0;
         if (c_busy) begin
            c_cnt--;
            if (c_cnt == 0) begin i_ready = 1; i_rdata = $urandom; c_busy = 0; end
         end else if (!prev_req && $urandom_range(0, 9) == 0) begin
            i_ready = 1; i_rdata = $urandom;
         end

         @(negedge i_clock);
         chk1("r_request", o_request, m_owner != 0);
         if (m_owner != 0) begin
            chk32("r_address", o_address, m_addr);
            chk32("r_wdata",   o_wdata,   m_wdata);
            chk1 ("r_rw",      o_rw,      m_rw);
            chk1 ("r_flush",   o_flush,   m_flush);
            chk1 ("r_cach",    o_cacheable, m_cach);
         end
         chk1("r_a_ready", o_a_ready, i_ready && m_owner == 1);
         chk1("r_b_ready", o_b_ready, i_ready && m_owner == 2);
         if (i_ready && m_owner == 1) chk32("r_a_rdata", o_a_rdata, i_rdata);
         if (i_ready && m_owner == 2) chk32("r_b_rdata", o_b_rdata, i_rdata);
         chk32("r_grants_a", o_grants_a, m_ga);
         chk32("r_grants_b", o_grants_b, m_gb);

         // agents observe this cycle
         a_done = o_a_ready;
         b_done = o_b_ready;
         if (!c_busy && o_request && !i_ready) begin
            c_busy = 1;
            c_cnt  = $urandom_range(1, 3);
         end
         prev_req = o_request;

         // model: owner completes on ready; next decision two cycles later
         if (m_owner != 0) begin
            if (i_ready) begin
               if (m_owner == 1) begin m_ga++; m_prio = 1; m_locked = i_a_lock; end
               else begin m_gb++; m_prio = 0; m_locked = 0; end
               m_owner   = 0;
               m_idle_at = n + 2;
            end
         end else if (n >= m_idle_at) begin
            want_a = i_a_request;
            want_b = i_b_request && !m_locked;
            if (want_a && want_b) m_pick = m_prio ? 2 : 1;
            else if (want_a)      m_pick = 1;
            else if (want_b)      m_pick = 2;
            else                  m_pick = 0;
            if (m_locked && !i_a_lock) m_locked = 0;
            if (m_pick == 1) begin
               m_owner = 1; m_rw = i_a_rw; m_flush = i_a_flush; m_cach = i_a_cacheable;
               m_addr = i_a_address; m_wdata = i_a_wdata;
            end else if (m_pick == 2) begin
               m_owner = 2; m_rw = i_b_rw; m_flush = i_b_flush; m_cach = i_b_cacheable;
               m_addr = i_b_address; m_wdata = i_b_wdata;
            end
         end

         tick();
         n++;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cpu_dcache_arbiter.md
# cpu_dcache_arbiter

Two-requester arbiter that shares the single data cache port between the CPU memory stage (port A) and a secondary master (port B: debug/DMA). It grants one requester at a time with round-robin fairness and forwards rw/address/wdata/flush/cacheable to the cache. It returns the cache's ready/rdata only to the granted requester. Port A may lock the cache across consecutive transactions so that atomic read-modify-write sequences are not interleaved with port B.

## Interface
- Parameters: none.
- i_clock  in  1  sole clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_a_rw, i_a_request, i_a_flush, i_a_cacheable  in  1 each  port A command (rw=1 write).
- i_a_lock  in  1  port A keeps grant after current transaction completes.
- i_a_address, i_a_wdata  in  32 each  port A address / write data.
- o_a_ready  out  1  one-cycle completion pulse to A.
- o_a_rdata  out  32  read data to A, valid when o_a_ready.
- i_b_rw, i_b_request, i_b_flush, i_b_cacheable  in  1 each  port B command.
- i_b_address, i_b_wdata  in  32 each  port B address / write data.
- o_b_ready  out  1  one-cycle completion pulse to B.
- o_b_rdata  out  32  read data to B.
- o_rw, o_request, o_flush, o_cacheable  out  1 each  registered command to data cache.
- o_address, o_wdata  out  32 each  registered address / write data to data cache.
- i_ready  in  1  cache completion pulse.
- i_rdata  in  32  cache read data.
- o_grants_a, o_grants_b  out  32 each  debug: completed transactions per port; wrap at 2^32.

## Operation
- Requester protocol: hold request and fields stable until ready pulses, then drop request within one cycle. A request still high in the cycle after ready is treated as a new request.
- States: IDLE, GRANT_A, GRANT_B, RELEASE.
- IDLE:
  - Only one port requesting → grant it.
  - Both requesting → grant port indicated by `prio` (0=A, 1=B).
  - On grant: latch that port's rw/flush/cacheable/address/wdata into the o_* registers, set o_request=1, and go to GRANT_x.
- GRANT_x:
  - o_* held stable.
  - On i_ready: o_request←0, increment o_grants_x, `prio`←other port.
  - Then, if x==A and i_a_lock==1 (sampled in the i_ready cycle), go to RELEASE with `locked`←1. Otherwise go to RELEASE with `locked`←0.
- RELEASE:
  - Single cycle, o_request=0. This guarantees the cache sees request low after its ready pulse.
  - Then → IDLE.
- Locked IDLE: while `locked`=1, only port A can be granted. Port B waits regardless of `prio`. `locked` clears when a GRANT_A completes with i_a_lock=0, or when i_a_lock is low in IDLE.
- Ready/rdata forwarding (combinational):
  - o_a_ready = i_ready & (state==GRANT_A); o_b_ready likewise for GRANT_B.
  - o_a_rdata = o_b_rdata = i_rdata (qualified by the respective ready).
- i_ready outside GRANT_x is ignored; no counter changes.
- Flush is an ordinary transaction: forwarded with o_flush=1 and completed on i_ready. No special priority.

## Timing
- Reset values: state=IDLE, prio=0, locked=0, o_request=0, o_rw=0, o_flush=0, o_cacheable=0, o_address=0, o_wdata=0, o_grants_a=o_grants_b=0. o_a_ready and o_b_ready are 0 because state≠GRANT.
- Arbitration latency: request high in IDLE at edge N → o_request=1 after edge N+1 (one cycle).
- Completion: o_x_ready is asserted in the same cycle as i_ready (zero added latency).
- Turnaround: ready cycle → RELEASE → IDLE → next grant. Back-to-back transactions from one port therefore cost 3 cycles of arbiter overhead plus cache latency.
- Simultaneous requests with prio=0 → A first, then B. Alternation holds under sustained contention.
- Reset mid-transaction (any state): next edge returns to IDLE with o_request=0. An i_ready arriving in the reset cycle is not forwarded and not counted.
- Requester drops request while granted: not legal. The arbiter still holds the grant until i_ready.

## Test plan
- Reset, then A read of 0x0000_1000: o_request rises 1 cycle later with o_address=0x1000. Cache answers i_rdata=0xDEAD_BEEF after 3 cycles → o_a_ready=1 and o_a_rdata=0xDEAD_BEEF in that cycle, o_grants_a=1, o_b_ready stays 0.
- A and B request in the same cycle from reset: A is served first; B is granted in the IDLE cycle after RELEASE. Repeat both continuously for 10 transactions: alternation ABAB…, o_grants_a=o_grants_b=5.
- A sets i_a_lock=1 for a read+write to 0x2000 while B requests continuously: both A transactions complete before B is granted. B is granted after A's write completes with i_a_lock=0.
- B flush (i_b_flush=1): o_flush=1 held until i_ready. A request during the flush waits and is granted after RELEASE.
- Assert i_reset in GRANT_B with i_ready in the same cycle: o_b_ready=0, o_grants_b unchanged, state IDLE and o_request=0 next cycle.
- Stray i_ready pulse in IDLE: no o_a_ready/o_b_ready, counters unchanged.
